nf_uart_reg_dump: RTL and testbench
===================================

# nf_uart_reg_dump

Debug-output stage that sits directly downstream of the CPU's register scan port, alongside the seven-segment and VGA debug paths. On request it sweeps scan addresses 0..31, captures each 32-bit `reg_data` word, and transmits it as ASCII text over a UART 8N1 line. It drives `reg_addr` itself, so the board top selects between this block and the switch/key address source.

## Interface
Parameters:
- `CLK_DIV`, 434: clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- `AUTO_PERIOD`, 50_000_000: idle cycles between automatic dumps (used only with `NF_REG_DUMP_AUTO_EN`).

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  asynchronous active-low reset.
- `start`  in  1  dump request; level-sampled in IDLE only.
- `reg_addr`  out  5  scan register address to CPU.
- `reg_data`  in  32  scan register data from CPU (combinational from `reg_addr`).
- `uart_tx`  out  1  serial output, idle high.
- `busy`  out  1  high from the cycle after acceptance until DONE.
- `done`  out  1  one-cycle pulse at end of dump.

## Operation
- Line format per register: 2 hex digits of address, `:`, 8 hex digits of data MSB-first, CR (0x0D), LF (0x0A). 13 bytes per line, 32 lines per dump.
- Hex digits are uppercase: 0-9 map to 0x30-0x39, A-F to 0x41-0x46.
- FSM states:
  - IDLE: `start`=1 leads to ADDR, with the address counter cleared.
  - ADDR: `reg_addr` is driven from the counter; always leads to CAPT.
  - CAPT: latches `reg_data` into a 32-bit shadow register; character index set to 0; leads to TX.
  - TX: sends the 13 characters back-to-back; after the LF stop bit, goes to DONE if the address is 31, else increments the address and goes to ADDR.
  - DONE: `done`=1 for one cycle; leads to IDLE.
- `reg_addr` is held stable from ADDR through the end of that line's TX. Data is taken only from the shadow register, so CPU register changes mid-line do not alter the line.
- UART framing, LSB first: start bit 0, 8 data bits, stop bit 1. Each bit lasts exactly `CLK_DIV` cycles. The next character's start bit immediately follows the previous stop bit.
- `start` asserted while `busy` is ignored; there is no queueing.
- An address counter wrap from 31 never occurs; termination is at 31.

## Timing
- Reset values: `reg_addr`=0, `uart_tx`=1, `busy`=0, `done`=0, FSM=IDLE, counters 0, shadow register 0.
- Reset asserted mid-operation forces reset values immediately, including `uart_tx`=1 mid-frame. The partial character is abandoned.
- Cycle timeline, with `start` sampled high at edge 0:
  - `busy`=1 and `reg_addr` valid from edge 1 (ADDR).
  - Capture at edge 2.
  - `uart_tx` falls at edge 3.
- One line lasts 2 + 130·`CLK_DIV` cycles. A full dump lasts 32·(2 + 130·`CLK_DIV`) + 1 cycles, measured from edge 1 up to the `done` pulse.
- `busy` falls in the same cycle `done` pulses.
- Bit-period counter width is 16 bits. Character index is 4 bits (0..12). Bit index is 4 bits (0..9).

## Configuration
- `NF_REG_DUMP_AUTO_EN`
  - Defined: after DONE, an idle counter runs in IDLE. When it reaches `AUTO_PERIOD`-1 the block self-starts exactly as if `start`=1. An external `start` during the wait starts immediately and clears the counter. Reset clears the counter.
  - Undefined: the counter logic is absent; dumps occur only on `start`.

## Test plan
- Reset, then idle 100 cycles with `start`=0 -> `uart_tx`=1, `busy`=0, `reg_addr`=0 throughout.
- `CLK_DIV`=4, model returns `reg_data`=0xDEADBEEF for address 5 -> line 5 decodes to "05:DEADBEEF\r\n". `uart_tx` first falls 3 cycles after `start`. Each bit lasts 4 cycles.
- `CLK_DIV`=4, model returns {27'h0, addr} -> 32 lines "00:00000000" through "1F:0000001F". `done` pulses once at cycle 32·522+1 after acceptance; `busy` falls with it.
- Model changes `reg_data` during TX of line 3 -> line 3 text unchanged; `reg_addr` stays 3 for the entire line.
- `start` pulsed again mid-dump, then `resetn` dropped during a character -> second `start` has no effect. On reset, `uart_tx`=1, `busy`=0 and `reg_addr`=0 immediately. A new `start` after reset begins at address 0.
- `NF_REG_DUMP_AUTO_EN` with `AUTO_PERIOD`=50, `CLK_DIV`=2 -> second dump's `busy` rises 51 cycles after first `done`, with no `start` applied.

Source files
------------

// File: rtl/nf_uart_reg_dump.sv
// Sweeps CPU scan registers 0..31 and prints each as "AA:DDDDDDDD\r\n" over UART 8N1.
// Optional macro NF_REG_DUMP_AUTO_EN: self-restart after AUTO_PERIOD idle cycles following a dump.
module nf_uart_reg_dump #(
    parameter int CLK_DIV     = 434,
    parameter int AUTO_PERIOD = 50_000_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    output logic [4:0]  reg_addr,
    input  logic [31:0] reg_data,
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);

    generate
        if (CLK_DIV < 2 || CLK_DIV > 65535 || AUTO_PERIOD < 1) begin : g_param_check
            $error("nf_uart_reg_dump: parameter out of range");
        end
    endgenerate

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CAPT,
        S_TX,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic        start_q;
    logic        auto_go;
    logic [15:0] baud_cnt, baud_nxt;
    logic [3:0]  char_idx, char_nxt;
    logic [3:0]  bit_idx, bit_nxt;
    logic [4:0]  addr_nxt;
    logic [31:0] shadow;
    logic        cap_en;
    logic        tx_nxt;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Character positions: 0-1 address, 2 colon, 3-10 data nibbles MSB first, 11 CR, 12 LF.
    function automatic logic [7:0] char_code(input logic [3:0] idx, input logic [4:0] a,
                                             input logic [31:0] d);
        logic [7:0] c;
        logic [2:0] nib;
        nib = 3'(4'd10 - idx);
        case (idx)
            4'd0:    c = hex_ascii({3'b000, a[4]});
            4'd1:    c = hex_ascii(a[3:0]);
            4'd2:    c = 8'h3A;
            4'd11:   c = 8'h0D;
            4'd12:   c = 8'h0A;
            default: c = hex_ascii(4'(d >> {nib, 2'b00}));
        endcase
        return c;
    endfunction

    // Bit 0 is the start bit, 1..8 carry data LSB first, 9 is the stop bit.
    function automatic logic frame_bit(input logic [3:0] b, input logic [7:0] c);
        if (b == 4'd0) begin
            return 1'b0;
        end else if (b >= 4'd9) begin
            return 1'b1;
        end
        return 1'(c >> (b - 4'd1));
    endfunction

`ifdef NF_REG_DUMP_AUTO_EN
    localparam logic [31:0] AUTO_LAST = 32'(AUTO_PERIOD - 1);
    logic [31:0] idle_cnt;
    logic        auto_arm;

    assign auto_go = auto_arm && (state == S_IDLE) && (idle_cnt == AUTO_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idle_cnt <= '0;
            auto_arm <= 1'b0;
        end else if (state == S_DONE) begin
            idle_cnt <= '0;
            auto_arm <= 1'b1;
        end else if (state == S_IDLE) begin
            if (start_q || auto_go) begin
                idle_cnt <= '0;
            end else if (auto_arm) begin
                idle_cnt <= idle_cnt + 32'd1;
            end
        end
    end
`else
    assign auto_go = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        char_nxt  = char_idx;
        bit_nxt   = bit_idx;
        addr_nxt  = reg_addr;
        cap_en    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_q || auto_go) begin
                    state_nxt = S_ADDR;
                    addr_nxt  = 5'd0;
                end
            end
            S_ADDR: begin
                state_nxt = S_CAPT;
                cap_en    = 1'b1;
            end
            S_CAPT: begin
                state_nxt = S_TX;
                char_nxt  = 4'd0;
                bit_nxt   = 4'd0;
                baud_nxt  = 16'd0;
            end
            S_TX: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt = 16'd0;
                    if (bit_idx == 4'd9) begin
                        bit_nxt = 4'd0;
                        if (char_idx == 4'd12) begin
                            if (reg_addr == 5'd31) begin
                                state_nxt = S_DONE;
                            end else begin
                                addr_nxt  = reg_addr + 5'd1;
                                state_nxt = S_ADDR;
                            end
                        end else begin
                            char_nxt = char_idx + 4'd1;
                        end
                    end else begin
                        bit_nxt = bit_idx + 4'd1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Line level is registered, so it is computed from next-cycle indices.
        tx_nxt = 1'b1;
        if (state_nxt == S_TX) begin
            tx_nxt = frame_bit(bit_nxt, char_code(char_nxt, reg_addr, shadow));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            start_q  <= 1'b0;
            baud_cnt <= '0;
            char_idx <= '0;
            bit_idx  <= '0;
            reg_addr <= '0;
            shadow   <= '0;
            uart_tx  <= 1'b1;
        end else begin
            state    <= state_nxt;
            start_q  <= start;
            baud_cnt <= baud_nxt;
            char_idx <= char_nxt;
            bit_idx  <= bit_nxt;
            reg_addr <= addr_nxt;
            uart_tx  <= tx_nxt;
            if (cap_en) begin
                shadow <= reg_data;
            end
        end
    end

    assign busy = (state == S_ADDR) || (state == S_CAPT) || (state == S_TX);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_nf_uart_reg_dump.sv
// Directed bench for nf_uart_reg_dump: decodes the UART line and checks text, timing and reset.
module tb_nf_uart_reg_dump;

    localparam int CLK_DIV     = 4;
    localparam int AUTO_PERIOD = 50;
    localparam int LINE_CYC    = 2 + 130 * CLK_DIV;
    localparam int DUMP_CYC    = 32 * LINE_CYC + 1;
    localparam int BIT_T       = 10 * CLK_DIV;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        uart_tx;
    logic        busy;
    logic        done;

    logic [31:0] mem [32];
    logic        corrupt_en = 1'b0;
    int          hold3 = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    int          acc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          rx_ferr = 0;
    byte         rx_q [$];

    assign reg_data = (corrupt_en && hold3 >= 100 && reg_addr == 5'd3) ? 32'h1234_5678
                                                                       : mem[reg_addr];

    nf_uart_reg_dump #(
        .CLK_DIV    (CLK_DIV),
        .AUTO_PERIOD(AUTO_PERIOD)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .reg_addr(reg_addr),
        .reg_data(reg_data),
        .uart_tx (uart_tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (busy && reg_addr == 5'd3) hold3 <= hold3 + 1;
    end

    // Mid-bit sampling receiver; offsets keep samples clear of both clock edges.
    always begin : rx
        logic [7:0] b;
        @(negedge uart_tx);
        #23;
        for (int i = 0; i < 8; i++) begin
            #(BIT_T);
            b[i] = uart_tx;
        end
        #(BIT_T);
        if (uart_tx !== 1'b1) rx_ferr++;
        rx_q.push_back(b);
    end

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        string       exp;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic chk_s(input string name, input string got, input string exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got \"%s\", expected \"%s\"", name, got.substr(0, 10),
                      exp.substr(0, 10));
    endtask

    function automatic string hexs(input logic [31:0] v, input int n);
        string digits = "0123456789ABCDEF";
        string s = "";
        for (int i = n - 1; i >= 0; i--) s = $sformatf("%s%c", s, digits[v[i*4 +: 4]]);
        return s;
    endfunction

    function automatic string get_line(input int base, input int idx);
        string s = "";
        if (rx_q.size() < base + 13 * (idx + 1)) return s;
        for (int k = 0; k < 13; k++) s = $sformatf("%s%c", s, rx_q[base + 13 * idx + k]);
        return s;
    endfunction

    task do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        acc = cyc;
    endtask

    initial begin
        int base;
        int errs;
        int cnt;
        int d_cyc;
        string exp_line;

        tbl[0] = '{5'd5,  32'hDEAD_BEEF, "05:DEADBEEF"};
        tbl[1] = '{5'd0,  32'h0000_0000, "00:00000000"};
        tbl[2] = '{5'd10, 32'h0123_ABCD, "0A:0123ABCD"};
        tbl[3] = '{5'd16, 32'hA5A5_5A5A, "10:A5A55A5A"};
        tbl[4] = '{5'd25, 32'h89AB_CDEF, "19:89ABCDEF"};
        tbl[5] = '{5'd31, 32'hFFFF_FFFF, "1F:FFFFFFFF"};
        for (int a = 0; a < 32; a++) mem[a] = 32'(a);
        for (int i = 0; i < 6; i++) mem[tbl[i].addr] = tbl[i].data;

        // Reset values and quiet idle
        repeat (3) @(negedge clk);
        chk("rst_uart_tx", 32'(uart_tx), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_reg_addr", 32'(reg_addr), 0);
        resetn = 1'b1;
        errs = 0;
        repeat (100) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || reg_addr !== 5'd0) errs++;
        end
        chk("idle_quiet_errs", errs, 0);

        // Full dump with table data and a mid-line data change on address 3
        corrupt_en = 1'b1;
        base = rx_q.size();
        do_start();
        chk("busy_edge0", 32'(busy), 0);
        @(negedge clk);
        chk("busy_edge1", 32'(busy), 1);
        chk("addr_edge1", 32'(reg_addr), 0);
        @(negedge clk);
        chk("tx_edge2", 32'(uart_tx), 1);
        @(negedge clk);
        chk("tx_edge3", 32'(uart_tx), 0);
        cnt = 0;
        while (uart_tx === 1'b0 && cnt < 100) begin cnt++; @(negedge clk); end
        chk("first_low_run", cnt, 5 * CLK_DIV);
        cnt = 0;
        while (uart_tx === 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
        chk("first_high_run", cnt, 2 * CLK_DIV);

        cnt = 0;
        while (done !== 1'b1 && cnt < DUMP_CYC + 200) begin @(negedge clk); cnt++; end
        chk("done_cycle", cyc - acc, DUMP_CYC);
        chk("busy_at_done", 32'(busy), 0);
        d_cyc = cyc;
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);
        repeat (5) @(negedge clk);
        chk("done_pulses", done_cnt, 1);
        chk("rx_byte_count", rx_q.size() - base, 32 * 13);
        chk("rx_frame_errs", rx_ferr, 0);
        chk("addr3_hold_cycles", hold3, LINE_CYC);

        for (int i = 0; i < 6; i++)
            chk_s($sformatf("line_%0d", tbl[i].addr), get_line(base, int'(tbl[i].addr)),
                  {tbl[i].exp, "\r\n"});
        chk_s("line3_unchanged", get_line(base, 3), "03:00000003\r\n");
        errs = 0;
        for (int a = 0; a < 32; a++) begin
            exp_line = $sformatf("%s:%s\r\n", hexs(32'(a), 2), hexs(32'(a), 8));
            if (mem[a] == 32'(a) && get_line(base, a) != exp_line) errs++;
        end
        chk("plain_line_errs", errs, 0);
        corrupt_en = 1'b0;

`ifdef NF_REG_DUMP_AUTO_EN
        cnt = 0;
        while (busy !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
        chk("auto_restart_delay", cyc - d_cyc, AUTO_PERIOD + 1);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (70) @(negedge clk);
`else
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        chk("no_auto_restart", cnt, 0);
`endif

        // Second start ignored while busy, then reset mid-character
        do_start();
        while (cyc < acc + 600) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < acc + 1000) @(negedge clk);
        chk("restart_ignored_busy", 32'(busy), 1);
        chk("restart_ignored_addr", 32'(reg_addr), 1);
        cnt = 0;
        while (uart_tx !== 1'b0 && cnt < 100) begin @(negedge clk); cnt++; end
        resetn = 1'b0;
        #1;
        chk("midframe_rst_tx", 32'(uart_tx), 1);
        chk("midframe_rst_busy", 32'(busy), 0);
        chk("midframe_rst_addr", 32'(reg_addr), 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (70) @(negedge clk);

        base = rx_q.size();
        do_start();
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 1);
        chk("post_rst_addr", 32'(reg_addr), 0);
        cnt = 0;
        while (rx_q.size() < base + 13 && cnt < 2 * LINE_CYC) begin @(negedge clk); cnt++; end
        chk_s("post_rst_line0", get_line(base, 0), "00:00000000\r\n");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
